if_inst_recv: RTL



---
 rtl/if_inst_recv.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/if_inst_recv.sv
// if_inst_recv: instruction-fetch response capture for the front end.
//
// Each issued request is held in a one-entry pending register for the one
// cycle it takes the synchronous SRAM to answer. The returned word is paired
// with its PC and fetch exception code and pushed into a small circular FIFO
// whose head is offered to decode. A flush drops both the buffered entries
// and the in-flight response, but keeps a request fired in the same cycle.
//
// Ports:
//   clk             in   clock, rising edge
//   reset           in   synchronous active-high reset
//   req_fire        in   fetch request issued this cycle
//   req_pc          in   PC of the issued request
//   req_exc         in   fetch exception code of the request (0 = none)
//   inst_sram_rdata in   SRAM read data, valid the cycle after the request
//   id_ready        in   decode accepts the head entry
//   flush           in   pipeline redirect, kills all older fetches
//   fetch_ready     out  a new request may be issued this cycle
//   id_valid        out  FIFO head present
//   id_inst         out  head instruction (0 when empty)
//   id_pc           out  head PC (0 when empty)
//   id_exc          out  head exception code (0 when empty)

module if_inst_recv #(
   parameter int unsigned DEPTH = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_fire,
   input  logic [31:0] req_pc,
   input  logic [4:0]  req_exc,
   input  logic [31:0] inst_sram_rdata,
   input  logic        id_ready,
   input  logic        flush,
   output logic        fetch_ready,
   output logic        id_valid,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [4:0]  id_exc
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = CW + 1;

   // Pending (in-flight) request
   logic        pend_v;
   logic [31:0] pend_pc;
   logic [4:0]  pend_exc;

   // FIFO state
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   mem_inst [DEPTH];
   logic [31:0]   mem_pc   [DEPTH];
   logic [4:0]    mem_exc  [DEPTH];

   logic          push, pop;
   logic [31:0]   push_inst;
   logic [CW-1:0] count_d;
   logic [OW-1:0] occupancy;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      push      = pend_v & ~flush;
      pop       = id_valid & id_ready;
      // Faulting fetches never touched the SRAM; substitute a nop.
      push_inst = (pend_exc == 5'd0) ? inst_sram_rdata : 32'h0;
      count_d   = count;
      if (push && !pop) begin
         count_d = count + CW'(1);
      end else if (pop && !push) begin
         count_d = count - CW'(1);
      end
   end

   // Pending request register; a request fired during a flush is the
   // redirect target and is kept.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_v   <= 1'b0;
         pend_pc  <= 32'h0;
         pend_exc <= 5'd0;
      end else begin
         pend_v <= req_fire;
         if (req_fire) begin
            pend_pc  <= req_pc;
            pend_exc <= req_exc;
         end
      end
   end

   // FIFO control; flush overrides push and pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count_d;
      end
   end

   // Storage needs no reset: outputs are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem_inst[wr_ptr] <= push_inst;
         mem_pc[wr_ptr]   <= pend_pc;
         mem_exc[wr_ptr]  <= pend_exc;
      end
   end

   // Backpressure guarantees room for every in-flight word.
   always_ff @(posedge clk) begin
      if (!reset && push && !pop) begin
         assert (count < CW'(DEPTH));
      end
   end

   always_comb begin
      // Reserve a slot for the in-flight response: registered state only.
      occupancy   = OW'(count) + OW'(pend_v);
      fetch_ready = occupancy < OW'(DEPTH);
      id_valid    = (count != '0);
      id_inst     = 32'h0;
      id_pc       = 32'h0;
      id_exc      = 5'd0;
      if (id_valid) begin
         id_inst = mem_inst[rd_ptr];
         id_pc   = mem_pc[rd_ptr];
         id_exc  = mem_exc[rd_ptr];
      end
   end

endmodule
